// File: rtl/d_reg_pipeline_pkg.sv
// rtl/d_reg_pipeline_pkg.sv - shared constants and width helpers for the register pipeline
package d_reg_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    function automatic int clog2(input int value);
        int r;
        int x;
        r = 0;
        x = value - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // occ must represent 0..depth inclusive, and never collapse to zero bits
    function automatic int cnt_w(input int depth);
        return (clog2(depth + 1) < 1) ? 1 : clog2(depth + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_w(DEF_DEPTH);

endpackage

// File: rtl/d_reg_pipeline_if.sv
// rtl/d_reg_pipeline_if.sv - input/output bundle of the register pipeline
interface d_reg_pipeline_if
    import d_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CNT_W = cnt_w(DEPTH);

    logic                   en;
    logic                   flush;
    logic [WIDTH-1:0]       d;
    logic                   d_vld;
    logic [WIDTH-1:0]       q;
    logic                   q_vld;
    logic [WIDTH*DEPTH-1:0] q_taps;
    logic [CNT_W-1:0]       occ;

    modport master (output en, flush, d, d_vld, input q, q_vld, q_taps, occ);
    modport slave  (input en, flush, d, d_vld, output q, q_vld, q_taps, occ);

endinterface

// File: rtl/d_reg_pipeline_stage.sv
// rtl/d_reg_pipeline_stage.sv - one data+valid stage with advance enable and flush
module d_reg_stage #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    output logic [WIDTH-1:0] q,
    output logic             q_vld
);

    // Data follows en even during flush; only the valid bit is cleared.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q     <= RST_VAL;
            q_vld <= 1'b0;
        end else begin
            if (en)
                q <= d;
            if (flush)
                q_vld <= 1'b0;
            else if (en)
                q_vld <= d_vld;
        end
    end

endmodule

// File: rtl/d_reg_pipeline.sv
// rtl/d_reg_pipeline.sv - DEPTH-stage register delay line with valid tracking and occupancy
module d_reg_pipeline
    import d_reg_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter int               DEPTH   = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rstn,
    d_reg_pipeline_if.slave   bus
);

    localparam int CNT_W = cnt_w(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] tap_q;
    logic [DEPTH-1:0]            vld_q;
    logic [CNT_W-1:0]            occ_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] stage_d;
        logic             stage_vld;
        if (i == 0) begin : g_head
            assign stage_d   = bus.d;
            assign stage_vld = bus.d_vld;
        end else begin : g_body
            assign stage_d   = tap_q[i-1];
            assign stage_vld = vld_q[i-1];
        end
        d_reg_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk   (clk),
            .rstn  (rstn),
            .en    (bus.en),
            .flush (bus.flush),
            .d     (stage_d),
            .d_vld (stage_vld),
            .q     (tap_q[i]),
            .q_vld (vld_q[i])
        );
    end

    // Incremental count: an entry enters at stage 0 and leaves from the last stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            occ_q <= '0;
        else if (bus.flush)
            occ_q <= '0;
        else if (bus.en)
            occ_q <= occ_q + CNT_W'(bus.d_vld) - CNT_W'(vld_q[DEPTH-1]);
    end

    assign bus.q      = tap_q[DEPTH-1];
    assign bus.q_vld  = vld_q[DEPTH-1];
    assign bus.q_taps = tap_q;
    assign bus.occ    = occ_q;

endmodule
